// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - Pong score keeper: point scoring, post-point ball hold, game over and serve restart.
// Collisions and VSync are edge-detected in the clk domain; Serve is synchronized first.
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       VSync,
  input  logic       LftCollision,
  input  logic       RgtCollision,
  input  logic       Serve,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR,
  output logic       BallHold,
  output logic       GameOver,
  output logic [1:0] Winner
);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    HOLD = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] HF  = 8'(HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] scl_q, scl_d, scr_q, scr_d;
  logic [1:0] win_q, win_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hold_q, over_q;
  logic       lft_q, rgt_q, vs_q;
  logic       srv1_q, srv2_q, srv3_q;

  logic lft_rise, rgt_rise, vs_fall, serve_rise;

  assign lft_rise   = LftCollision & ~lft_q;
  assign rgt_rise   = RgtCollision & ~rgt_q;
  assign vs_fall    = ~VSync & vs_q;
  assign serve_rise = srv2_q & ~srv3_q;

  always_comb begin
    state_d = state_q;
    scl_d   = scl_q;
    scr_d   = scr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      PLAY: begin
        // A simultaneous hit on both walls is ambiguous, so neither side scores.
        if (lft_rise ^ rgt_rise) begin
          if (lft_rise) begin
            if (scr_q < WIN) scr_d = scr_q + 4'd1;
            if (scr_d == WIN) begin
              state_d = OVER;
              win_d   = 2'b10;
            end else begin
              state_d = HOLD;
              cnt_d   = HF;
            end
          end else begin
            if (scl_q < WIN) scl_d = scl_q + 4'd1;
            if (scl_d == WIN) begin
              state_d = OVER;
              win_d   = 2'b01;
            end else begin
              state_d = HOLD;
              cnt_d   = HF;
            end
          end
        end
      end
      HOLD: begin
        if (vs_fall) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      OVER: begin
        if (serve_rise) begin
          scl_d   = 4'd0;
          scr_d   = 4'd0;
          win_d   = 2'b00;
          cnt_d   = HF;
          state_d = HOLD;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PLAY;
      scl_q   <= 4'd0;
      scr_q   <= 4'd0;
      win_q   <= 2'b00;
      cnt_q   <= 8'd0;
      hold_q  <= 1'b0;
      over_q  <= 1'b0;
      lft_q   <= 1'b0;
      rgt_q   <= 1'b0;
      vs_q    <= 1'b1;
      srv1_q  <= 1'b0;
      srv2_q  <= 1'b0;
      srv3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q   <= scl_d;
      scr_q   <= scr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      hold_q  <= (state_d != PLAY);
      over_q  <= (state_d == OVER);
      lft_q   <= LftCollision;
      rgt_q   <= RgtCollision;
      vs_q    <= VSync;
      srv1_q  <= Serve;
      srv2_q  <= srv1_q;
      srv3_q  <= srv2_q;
    end
  end

  assign ScoreL   = scl_q;
  assign ScoreR   = scr_q;
  assign Winner   = win_q;
  assign BallHold = hold_q;
  assign GameOver = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - Randomized self-checking bench for score_keeper against an event-level game model.
module tb_score_keeper;

  localparam int WS = 9;
  localparam int HF = 60;

  logic clk = 1'b0;
  logic reset, VSync, LftCollision, RgtCollision, Serve;
  logic [3:0] ScoreL, ScoreR, ScoreL1, ScoreR1;
  logic BallHold, GameOver, BallHold1, GameOver1;
  logic [1:0] Winner, Winner1;
  logic [12:0] obs, obs1;

  int checks = 0;
  int failures = 0;

  // Event-level game model: mode 0 play, 1 hold, 2 over.
  int m_mode, m_sl, m_sr, m_win, m_cnt;

  always #5 clk = ~clk;

  score_keeper u_dut (
    .clk(clk), .reset(reset), .VSync(VSync), .LftCollision(LftCollision),
    .RgtCollision(RgtCollision), .Serve(Serve), .ScoreL(ScoreL), .ScoreR(ScoreR),
    .BallHold(BallHold), .GameOver(GameOver), .Winner(Winner)
  );

  score_keeper #(.WIN_SCORE(9), .HOLD_FRAMES(1)) u_one (
    .clk(clk), .reset(reset), .VSync(VSync), .LftCollision(LftCollision),
    .RgtCollision(RgtCollision), .Serve(Serve), .ScoreL(ScoreL1), .ScoreR(ScoreR1),
    .BallHold(BallHold1), .GameOver(GameOver1), .Winner(Winner1)
  );

  assign obs  = {ScoreL, ScoreR, BallHold, GameOver, Winner};
  assign obs1 = {ScoreL1, ScoreR1, BallHold1, GameOver1, Winner1};

  function automatic logic [12:0] model_vec();
    return {4'(m_sl), 4'(m_sr), 1'(m_mode != 0), 1'(m_mode == 2), 2'(m_win)};
  endfunction

  task automatic m_reset();
    m_mode = 0; m_sl = 0; m_sr = 0; m_win = 0; m_cnt = 0;
  endtask

  task automatic m_point(input bit l, input bit r);
    if (m_mode == 0 && l != r) begin
      if (l) m_sr = (m_sr < WS) ? m_sr + 1 : WS;
      else   m_sl = (m_sl < WS) ? m_sl + 1 : WS;
      if ((l && m_sr == WS) || (r && m_sl == WS)) begin
        m_mode = 2;
        m_win  = l ? 2 : 1;
      end else begin
        m_mode = 1;
        m_cnt  = HF;
      end
    end
  endtask

  task automatic m_frame();
    if (m_mode == 1) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_mode = 0;
    end
  endtask

  task automatic m_serve();
    if (m_mode == 2) begin
      m_sl = 0; m_sr = 0; m_win = 0; m_mode = 1; m_cnt = HF;
    end
  endtask

  task automatic pulse_coll(input bit l, input bit r, input int len);
    @(negedge clk);
    LftCollision = l;
    RgtCollision = r;
    repeat (len) @(negedge clk);
    LftCollision = 1'b0;
    RgtCollision = 1'b0;
    @(negedge clk);
    m_point(l, r);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      VSync = 1'b0;
      @(negedge clk);
      VSync = 1'b1;
      m_frame();
    end
  endtask

  task automatic serve_pulse(input int len);
    @(negedge clk);
    Serve = 1'b1;
    repeat (len) @(negedge clk);
    Serve = 1'b0;
    repeat (3) @(negedge clk);
    m_serve();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; VSync = 1'b1; LftCollision = 1'b0; RgtCollision = 1'b0; Serve = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 13'd0) begin failures++; $display("FAIL reset_main got=%h exp=%h", obs, 13'd0); end
    checks++;
    if (obs1 !== 13'd0) begin failures++; $display("FAIL reset_one got=%h exp=%h", obs1, 13'd0); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_point();
    pulse_coll(1'b1, 1'b0, 6);
    checks++;
    if (obs !== {4'd0, 4'd1, 1'b1, 1'b0, 2'b00}) begin failures++; $display("FAIL point_once got=%h exp=%h", obs, {4'd0, 4'd1, 1'b1, 1'b0, 2'b00}); end
    frames(HF - 1);
    checks++;
    if (obs !== model_vec()) begin failures++; $display("FAIL hold_59 got=%h exp=%h", obs, model_vec()); end
    frames(1);
    checks++;
    if (obs !== {4'd0, 4'd1, 1'b0, 1'b0, 2'b00}) begin failures++; $display("FAIL hold_release got=%h exp=%h", obs, {4'd0, 4'd1, 1'b0, 1'b0, 2'b00}); end
  endtask

  task automatic test_simultaneous();
    pulse_coll(1'b1, 1'b1, 3);
    checks++;
    if (obs !== model_vec() || BallHold !== 1'b0) begin failures++; $display("FAIL both_rise got=%h exp=%h", obs, model_vec()); end
  endtask

  task automatic test_serve_in_play();
    serve_pulse(3);
    checks++;
    if (obs !== model_vec()) begin failures++; $display("FAIL serve_in_play got=%h exp=%h", obs, model_vec()); end
  endtask

  task automatic test_win_left();
    while (m_sl < WS - 1) begin
      pulse_coll(1'b0, 1'b1, 4);
      frames(HF);
    end
    checks++;
    if (obs !== model_vec() || ScoreL !== 4'd8) begin failures++; $display("FAIL left_at_8 got=%h exp=%h", obs, model_vec()); end
    pulse_coll(1'b0, 1'b1, 5);
    checks++;
    if (obs !== {4'd9, 4'(m_sr), 1'b1, 1'b1, 2'b01}) begin failures++; $display("FAIL left_wins got=%h exp=%h", obs, {4'd9, 4'(m_sr), 1'b1, 1'b1, 2'b01}); end
    pulse_coll(1'b0, 1'b1, 3);
    pulse_coll(1'b1, 1'b0, 3);
    frames(3);
    checks++;
    if (obs !== model_vec() || ScoreL !== 4'd9) begin failures++; $display("FAIL over_ignores got=%h exp=%h", obs, model_vec()); end
  endtask

  task automatic test_serve_restart();
    @(negedge clk);
    Serve = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b1, 1'b0, 2'b00}) begin failures++; $display("FAIL serve_restart got=%h exp=%h", obs, {4'd0, 4'd0, 1'b1, 1'b0, 2'b00}); end
    Serve = 1'b0;
    repeat (3) @(negedge clk);
    m_serve();
    frames(HF - 1);
    checks++;
    if (obs !== model_vec() || BallHold !== 1'b1) begin failures++; $display("FAIL serve_hold_59 got=%h exp=%h", obs, model_vec()); end
    frames(1);
    checks++;
    if (obs !== model_vec() || BallHold !== 1'b0) begin failures++; $display("FAIL serve_hold_60 got=%h exp=%h", obs, model_vec()); end
  endtask

  task automatic test_reset_mid_hold();
    pulse_coll(1'b1, 1'b0, 2);
    frames(20);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 13'd0) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, 13'd0); end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    pulse_coll(1'b1, 1'b0, 3);
    checks++;
    if (obs !== {4'd0, 4'd1, 1'b1, 1'b0, 2'b00}) begin failures++; $display("FAIL post_reset_point got=%h exp=%h", obs, {4'd0, 4'd1, 1'b1, 1'b0, 2'b00}); end
    frames(HF - 1);
    checks++;
    if (BallHold !== 1'b1) begin failures++; $display("FAIL fresh_hold_59 got=%b exp=1", BallHold); end
    frames(1);
    checks++;
    if (BallHold !== 1'b0) begin failures++; $display("FAIL fresh_hold_60 got=%b exp=0", BallHold); end
  endtask

  task automatic test_hold_one();
    do_reset();
    pulse_coll(1'b1, 1'b0, 2);
    checks++;
    if (obs1 !== {4'd0, 4'd1, 1'b1, 1'b0, 2'b00}) begin failures++; $display("FAIL one_point got=%h exp=%h", obs1, {4'd0, 4'd1, 1'b1, 1'b0, 2'b00}); end
    @(negedge clk);
    VSync = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1 !== {4'd0, 4'd1, 1'b0, 1'b0, 2'b00}) begin failures++; $display("FAIL one_frame_release got=%h exp=%h", obs1, {4'd0, 4'd1, 1'b0, 1'b0, 2'b00}); end
    VSync = 1'b1;
    m_frame();
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    pulse_coll(1'b1, 1'b0, int'($urandom_range(1, 6)));
        2, 3:    pulse_coll(1'b0, 1'b1, int'($urandom_range(1, 6)));
        4:       pulse_coll(1'b1, 1'b1, int'($urandom_range(1, 4)));
        5, 6, 7: frames(int'($urandom_range(1, 30)));
        8:       serve_pulse(int'($urandom_range(1, 4)));
        default: frames(HF);
      endcase
      checks++;
      if (obs !== model_vec()) begin failures++; $display("FAIL random_%0d sel=%0d got=%h exp=%h", i, sel, obs, model_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_simultaneous();
    test_serve_in_play();
    test_win_left();
    test_serve_restart();
    test_reset_mid_hold();
    test_hold_one();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9, score (1..9) that ends the game.
REQ-002 Parameter HOLD_FRAMES, default 60, frames the ball stays frozen after a point (1..255).
REQ-003 clk  input  1  system clock, same domain as the ball mover and the VGA timing generator.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 VSync  input  1  vertical sync, active-low pulse once per frame, synchronous to clk.
REQ-006 LftCollision  input  1  ball reached the left wall; held high for several cycles per event.
REQ-007 RgtCollision  input  1  ball reached the right wall; held high for several cycles per event.
REQ-008 Serve  input  1  asynchronous push-button, active-high; restarts the game after game over.
REQ-009 ScoreL  output  4  left player score, binary 0..WIN_SCORE.
REQ-010 ScoreR  output  4  right player score, binary 0..WIN_SCORE.
REQ-011 BallHold  output  1  high while the ball must stay frozen (HOLD or OVER state).
REQ-012 GameOver  output  1  high in OVER state.
REQ-013 Winner  output  2  00 none, 01 left player, 10 right player; 11 never driven.

Function
REQ-014 The block SHALL implement a three-state FSM: PLAY, HOLD, OVER.
REQ-015 Collision inputs SHALL be rising-edge detected against a one-cycle registered copy; a level held for many cycles SHALL count once.
REQ-016 In PLAY, a LftCollision rise SHALL increment ScoreR; a RgtCollision rise SHALL increment ScoreL; the new score SHALL be visible the cycle after the rising input is sampled.
REQ-017 Both collision rises in the same cycle SHALL change no score and no state.
REQ-018 After an increment, if the new score equals WIN_SCORE the FSM SHALL enter OVER and set Winner; otherwise it SHALL enter HOLD and load the 8-bit frame counter with HOLD_FRAMES.
REQ-019 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-020 Collision rises in HOLD or OVER SHALL be ignored.
REQ-021 Frames SHALL be counted on VSync falling edges (registered-copy detect); in HOLD each falling edge decrements the counter, and the decrement that reaches 0 SHALL return the FSM to PLAY on the next clk.
REQ-022 Serve SHALL pass through a two-flop synchronizer followed by a rising-edge detector; Serve activity outside OVER SHALL be ignored.
REQ-023 In OVER, a synchronized Serve rise SHALL clear ScoreL, ScoreR and Winner, load the counter with HOLD_FRAMES and enter HOLD.
REQ-024 BallHold SHALL be 1 in HOLD and OVER and 0 in PLAY; GameOver SHALL be 1 only in OVER; both outputs SHALL be registered.
REQ-025 Any unused FSM encoding SHALL recover to PLAY on the next clk.

Reset
REQ-026 Reset high SHALL immediately clear ScoreL=0, ScoreR=0, Winner=00, GameOver=0 and BallHold=0, set the state to PLAY, clear the counter, and clear all edge-detect and synchronizer flops to 0.
REQ-027 The edge-detect copy of VSync SHALL reset to 1 so that the first low VSync after reset is treated as a falling edge.
REQ-028 Reset asserted mid-HOLD or in OVER SHALL abort to the REQ-026 state with no residual count.

Verification
REQ-029 PLAY, scores 0/0, LftCollision high for 6 cycles -> ScoreR=1 exactly once, BallHold=1; after 60 VSync falls -> BallHold=0, state PLAY.
REQ-030 ScoreL=8, RgtCollision rise -> ScoreL=9, GameOver=1, Winner=01, BallHold=1; further collisions leave ScoreL=9.
REQ-031 LftCollision and RgtCollision rise in the same cycle during PLAY -> scores unchanged, BallHold=0.
REQ-032 In OVER, Serve pulsed for 3 cycles -> 3 cycles later scores 0/0, Winner=00, GameOver=0, BallHold=1, HOLD counting from 60; Serve pulsed during PLAY -> no effect.
REQ-033 Reset asserted after 20 of 60 hold frames -> all outputs at their reset values at once; after release, a LftCollision rise gives ScoreR=1 with a fresh 60-frame hold.
REQ-034 HOLD_FRAMES=1: one VSync fall after a point -> PLAY on the next clk.
